// File: rtl/kelvin_pkg.sv
// Shared core definitions: data width, load/store encodings and LSU state type.
package kelvin_pkg;

   localparam int WORD_WIDTH = 32;

   // Load encodings carried in the EX/WB register
   localparam logic [2:0] LOAD_NONE = 3'd0;
   localparam logic [2:0] LB        = 3'd1;
   localparam logic [2:0] LH        = 3'd2;
   localparam logic [2:0] LW        = 3'd3;
   localparam logic [2:0] LBU       = 3'd4;
   localparam logic [2:0] LHU       = 3'd5;

   // Store encodings carried in the EX/WB register
   localparam logic [1:0] STORE_NONE = 2'd0;
   localparam logic [1:0] SB         = 2'd1;
   localparam logic [1:0] SH         = 2'd2;
   localparam logic [1:0] SW         = 2'd3;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_GNT    = 2'd1,
      WAIT_RVALID = 2'd2
   } lsu_state_t;

   // A store outranks a load in the same slot, so only the store's size matters then.
   function automatic logic is_misaligned(input logic [2:0] load_type,
                                          input logic [1:0] store_type,
                                          input logic [1:0] offset);
      logic mis;
      mis = 1'b0;
      if (store_type != STORE_NONE) begin
         mis = ((store_type == SH) && offset[0]) ||
               ((store_type == SW) && (offset != 2'b00));
      end else begin
         mis = (((load_type == LH) || (load_type == LHU)) && offset[0]) ||
               ((load_type == LW) && (offset != 2'b00));
      end
      return mis;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed byte/halfword down to bit 0 and extends it.
module lsu_load_align
   import kelvin_pkg::*;
(
   input  logic [WORD_WIDTH-1:0] rdata_i,
   input  logic [1:0]            offset_i,
   input  logic [2:0]            load_type_i,
   output logic [WORD_WIDTH-1:0] data_o
);

   logic [WORD_WIDTH-1:0] shifted;

   // Offset shift followed by sign or zero extension chosen by the load type
   always_comb begin
      shifted = rdata_i >> {offset_i, 3'b000};
      data_o  = shifted;
      case (load_type_i)
         LB:      data_o = {{24{shifted[7]}}, shifted[7:0]};
         LBU:     data_o = {24'd0, shifted[7:0]};
         LH:      data_o = {{16{shifted[15]}}, shifted[15:0]};
         LHU:     data_o = {16'd0, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: drives the req/gnt/rvalid data-memory interface for
// the access in the EX/WB slot, and stalls the pipeline until it completes.
//
// Handshake: data_req_o is held with address/be/wdata/we stable until a cycle where
// data_gnt_i is 1; that cycle accepts the request. For a load, the first cycle with
// data_rvalid_i = 1 after acceptance carries the read data. One access in flight.
module lsu_ctrl #(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  op_valid_i,
   input  logic [2:0]            load_type_i,
   input  logic [1:0]            store_type_i,
   input  logic [WORD_WIDTH-1:0] addr_i,
   input  logic [WORD_WIDTH-1:0] store_data_i,
   output logic                  data_req_o,
   output logic [WORD_WIDTH-1:0] data_addr_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [WORD_WIDTH-1:0] data_wdata_o,
   input  logic                  data_gnt_i,
   input  logic                  data_rvalid_i,
   input  logic [WORD_WIDTH-1:0] data_rdata_i,
   output logic [WORD_WIDTH-1:0] load_data_o,
   output logic                  load_valid_o,
   output logic                  stall_o,
   output logic                  misaligned_o
);

   import kelvin_pkg::*;

   lsu_state_t state_q, state_d;

   // Request fields captured when the access is launched from IDLE
   logic [WORD_WIDTH-1:0] addr_q, wdata_q;
   logic [3:0]            be_q;
   logic                  we_q;
   logic [2:0]            ltype_q;
   logic [1:0]            off_q;

   logic                  is_store, start, mis, latch_en;
   logic [3:0]            new_be;
   logic [WORD_WIDTH-1:0] new_wdata;

   logic                  req, we, stall, misaligned, load_valid;
   logic [3:0]            be;
   logic [WORD_WIDTH-1:0] addr, wdata, aligned;

   // Decode the slot: access kind, alignment, byte enables and replicated store data
   always_comb begin
      is_store  = (store_type_i != STORE_NONE);
      start     = op_valid_i && (is_store || (load_type_i != LOAD_NONE));
      mis       = is_misaligned(load_type_i, store_type_i, addr_i[1:0]);
      new_be    = 4'b1111;
      new_wdata = store_data_i;
      if (is_store) begin
         case (store_type_i)
            SB: begin
               new_be    = 4'b0001 << addr_i[1:0];
               new_wdata = {4{store_data_i[7:0]}};
            end
            SH: begin
               new_be    = 4'b0011 << addr_i[1:0];
               new_wdata = {2{store_data_i[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // Next-state and interface outputs; IDLE drives the request straight from the slot
   always_comb begin
      state_d    = state_q;
      req        = 1'b0;
      addr       = '0;
      we         = 1'b0;
      be         = 4'b0000;
      wdata      = '0;
      stall      = 1'b0;
      misaligned = 1'b0;
      load_valid = 1'b0;
      latch_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (mis) begin
                  misaligned = 1'b1;
               end else begin
                  req      = 1'b1;
                  addr     = {addr_i[WORD_WIDTH-1:2], 2'b00};
                  we       = is_store;
                  be       = new_be;
                  wdata    = new_wdata;
                  latch_en = 1'b1;
                  if (!data_gnt_i) begin
                     state_d = WAIT_GNT;
                     stall   = 1'b1;
                  end else if (!is_store) begin
                     state_d = WAIT_RVALID;
                     stall   = 1'b1;
                  end
               end
            end
         end
         WAIT_GNT: begin
            req   = 1'b1;
            addr  = addr_q;
            we    = we_q;
            be    = be_q;
            wdata = wdata_q;
            stall = 1'b1;
            if (data_gnt_i) begin
               if (we_q) begin
                  state_d = IDLE;
                  stall   = 1'b0;
               end else begin
                  state_d = WAIT_RVALID;
               end
            end
         end
         WAIT_RVALID: begin
            if (data_rvalid_i) begin
               load_valid = 1'b1;
               state_d    = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Capture the launched request so it stays stable while waiting for grant/data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= 4'b0000;
         we_q    <= 1'b0;
         ltype_q <= LOAD_NONE;
         off_q   <= 2'b00;
      end else if (latch_en) begin
         addr_q  <= {addr_i[WORD_WIDTH-1:2], 2'b00};
         wdata_q <= new_wdata;
         be_q    <= new_be;
         we_q    <= is_store;
         ltype_q <= is_store ? LOAD_NONE : load_type_i;
         off_q   <= addr_i[1:0];
      end
   end

   lsu_load_align u_load_align (
      .rdata_i     (data_rdata_i),
      .offset_i    (off_q),
      .load_type_i (ltype_q),
      .data_o      (aligned)
   );

   // All outputs are forced low while reset is held, including the combinational paths
   assign data_req_o   = rst_n && req;
   assign data_addr_o  = rst_n ? addr : '0;
   assign data_we_o    = rst_n && we;
   assign data_be_o    = rst_n ? be : 4'b0000;
   assign data_wdata_o = rst_n ? wdata : '0;
   assign load_valid_o = rst_n && load_valid;
   assign load_data_o  = (rst_n && load_valid) ? aligned : '0;
   assign stall_o      = rst_n && stall;
   assign misaligned_o = rst_n && misaligned;

endmodule
